spi_master_mc: RTL and testbench

//   Multi-chip-select SPI master: next generation of the single-channel SPI shifters.

---
 rtl/spi_master_mc.sv | 204 ++++++++++++++++++++
 tb/tb_spi_master_mc.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_mc.sv
// Multi-chip-select SPI master with programmable SCLK divider, CPOL, framed setup/hold and
// delayed IO-update strobe. Optional MISO capture is built when SPI_READBACK_EN is defined.
module spi_master_mc #(
  parameter int unsigned MAXWIDTH    = 128,
  parameter int unsigned NCS         = 4,
  parameter int unsigned CSW         = 2,
  parameter int unsigned DIVW        = 8,
  parameter int unsigned UPDATEDELAY = 0
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iTrig,
  input  logic [CSW-1:0]      iCsSel,
  input  logic [7:0]          iDataWidth,
  input  logic [MAXWIDTH-1:0] iData,
  input  logic [DIVW-1:0]     iClkDiv,
  input  logic                iCpol,
  input  logic                iAutoUpdate,
  input  logic                iUpdate,
  input  logic                iMiso,
  output logic                oSclk,
  output logic                oMosi,
  output logic [NCS-1:0]      oCSn,
  output logic                oUpdate,
  output logic                oReady,
  output logic [MAXWIDTH-1:0] oRdData,
  output logic                oRdValid
);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StWait} state_e;

  localparam int unsigned MaxN     = (MAXWIDTH > 255) ? 255 : MAXWIDTH;
  localparam logic [7:0]  MaxNB    = 8'(MaxN);
  localparam logic [3:0]  WaitInit = (UPDATEDELAY > 0) ? 4'(UPDATEDELAY - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [DIVW-1:0]     cnt_q, cnt_d;
  logic [DIVW-1:0]     div_q, div_d;
  logic [7:0]          bit_q, bit_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [MAXWIDTH-1:0] shreg_q, shreg_d;
  logic                cpol_q, cpol_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NCS-1:0]      csn_q, csn_d;
  logic                upd_q, upd_d;
  logic                accept, lead_edge, done;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      wcnt_q  <= '0;
      shreg_q <= '0;
      cpol_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= '1;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      wcnt_q  <= wcnt_d;
      shreg_q <= shreg_d;
      cpol_q  <= cpol_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
      upd_q   <= upd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_d     = bit_q;
    wcnt_d    = wcnt_q;
    shreg_d   = shreg_q;
    cpol_d    = cpol_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    csn_d     = csn_q;
    accept    = 1'b0;
    lead_edge = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (iTrig && (iDataWidth != 8'd0)) begin
          accept  = 1'b1;
          state_d = StSetup;
          shreg_d = iData;
          bit_d   = (iDataWidth > MaxNB) ? MaxNB : iDataWidth;
          div_d   = iClkDiv;
          cnt_d   = iClkDiv;
          cpol_d  = iCpol;
          sclk_d  = iCpol;
          mosi_d  = iData[MAXWIDTH-1];
          // An out-of-range select leaves every line high.
          for (int unsigned i = 0; i < NCS; i++) begin
            csn_d[i] = (32'(iCsSel) != i);
          end
        end
      end
      StSetup: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIVW'(1);
        end else begin
          cnt_d     = div_q;
          state_d   = StShift;
          sclk_d    = ~cpol_q;
          lead_edge = 1'b1;
        end
      end
      StShift: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIVW'(1);
        end else begin
          cnt_d = div_q;
          if (sclk_q != cpol_q) begin
            sclk_d  = cpol_q;
            shreg_d = shreg_q << 1;
            bit_d   = bit_q - 8'd1;
            // Nothing follows the last bit, so park MOSI low for its idle half.
            mosi_d  = (bit_q == 8'd1) ? 1'b0 : shreg_q[MAXWIDTH-2];
          end else if (bit_q == 8'd0) begin
            state_d = StHold;
            mosi_d  = 1'b0;
          end else begin
            sclk_d    = ~cpol_q;
            lead_edge = 1'b1;
          end
        end
      end
      StHold: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIVW'(1);
        end else begin
          csn_d = '1;
          if (UPDATEDELAY > 0) begin
            state_d = StWait;
            wcnt_d  = WaitInit;
          end else begin
            state_d = StIdle;
            done    = 1'b1;
          end
        end
      end
      StWait: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    upd_d = done;
  end

  assign oSclk   = sclk_q;
  assign oMosi   = mosi_q;
  assign oCSn    = csn_q;
  assign oReady  = (state_q == StIdle);
  assign oUpdate = iAutoUpdate ? upd_q : (iUpdate & oReady);

`ifdef SPI_READBACK_EN
  logic [MAXWIDTH-1:0] cap_q, rd_data_q;
  logic                rd_valid_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cap_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= done;
      if (accept) begin
        cap_q <= '0;
      end else if (lead_edge) begin
        cap_q <= {cap_q[MAXWIDTH-2:0], iMiso};
      end
      // Exactly N bits were shifted in after the clear, so they are already right-aligned.
      if (done) begin
        rd_data_q <= cap_q;
      end
    end
  end

  assign oRdData  = rd_data_q;
  assign oRdValid = rd_valid_q;
`else
  logic unused_rb;
  assign unused_rb = ^{iMiso, accept, lead_edge};
  assign oRdData   = '0;
  assign oRdValid  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed self-checking bench for spi_master_mc (default build; readback checks follow
// SPI_READBACK_EN when defined).
module tb_spi_master_mc;

  localparam int UD = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic         trig;
  logic [1:0]   cs_sel;
  logic [7:0]   data_width;
  logic [127:0] data_in;
  logic [7:0]   clk_div;
  logic         cpol_in;
  logic         auto_upd;
  logic         upd_in;
  logic         miso;
  logic         sclk;
  logic         mosi;
  logic [3:0]   csn;
  logic         upd;
  logic         ready;
  logic [127:0] rd_data;
  logic         rd_valid;

  int n_checks = 0;
  int n_pass   = 0;

  logic [127:0] got_bits, rdd_end;
  int           got_busy, got_nbits, got_act, upd_busy;
  logic         upd_end, upd_after, rdv_end, rdv_after;
  logic [3:0]   csn_seen, csn_mid;
  int           b, nr;

  always #5 clk = ~clk;

  assign miso = mosi;

  spi_master_mc #(
    .MAXWIDTH   (128),
    .NCS        (4),
    .CSW        (2),
    .DIVW       (8),
    .UPDATEDELAY(UD)
  ) dut (
    .iClk       (clk),
    .iRst       (rst),
    .iTrig      (trig),
    .iCsSel     (cs_sel),
    .iDataWidth (data_width),
    .iData      (data_in),
    .iClkDiv    (clk_div),
    .iCpol      (cpol_in),
    .iAutoUpdate(auto_upd),
    .iUpdate    (upd_in),
    .iMiso      (miso),
    .oSclk      (sclk),
    .oMosi      (mosi),
    .oCSn       (csn),
    .oUpdate    (upd),
    .oReady     (ready),
    .oRdData    (rd_data),
    .oRdValid   (rd_valid)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Launch one word from an idle negedge and watch it until oReady returns.
  task automatic xfer(input logic [7:0] n, input logic [127:0] data, input logic [7:0] div,
                      input logic cpol, input logic [1:0] cs);
    logic prev;
    data_width = n;
    data_in    = data;
    clk_div    = div;
    cpol_in    = cpol;
    cs_sel     = cs;
    trig       = 1'b1;
    @(negedge clk);
    trig      = 1'b0;
    got_busy  = 0;
    got_bits  = '0;
    got_nbits = 0;
    got_act   = 0;
    upd_busy  = 0;
    csn_seen  = csn;
    prev      = cpol;
    for (int i = 0; i < 4000 && !ready; i++) begin
      got_busy++;
      if (sclk != cpol) begin
        got_act++;
        if (prev == cpol) begin
          got_bits = {got_bits[126:0], mosi};
          got_nbits++;
        end
      end
      if (upd) upd_busy++;
      prev = sclk;
      @(negedge clk);
    end
    upd_end = upd;
    rdv_end = rd_valid;
    rdd_end = rd_data;
    @(negedge clk);
    upd_after = upd;
    rdv_after = rd_valid;
  endtask

  initial begin
    rst        = 1'b1;
    trig       = 1'b0;
    cs_sel     = '0;
    data_width = '0;
    data_in    = '0;
    clk_div    = '0;
    cpol_in    = 1'b0;
    auto_upd   = 1'b1;
    upd_in     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_csn", 128'(csn), 128'hF);
    check("rst_sclk", 128'(sclk), 128'h0);
    check("rst_mosi", 128'(mosi), 128'h0);
    check("rst_ready", 128'(ready), 128'h1);
    check("rst_upd", 128'(upd), 128'h0);
    check("rst_rdvalid", 128'(rd_valid), 128'h0);
    check("rst_rddata", rd_data, 128'h0);
    rst = 1'b0;
    @(negedge clk);

    // Word 1: 0xA5, D=0, CPOL=0, CS=2.
    xfer(8'd8, 128'hA5 << 120, 8'd0, 1'b0, 2'd2);
    check("t1_csn", 128'(csn_seen), 128'hB);
    check("t1_bits", got_bits, 128'hA5);
    check_int("t1_nbits", got_nbits, 8);
    check_int("t1_busy", got_busy, (2 * 8 + 2) * 1 + UD);
    check_int("t1_act", got_act, 8);
    check_int("t1_upd_busy", upd_busy, 0);
    check("t1_upd_end", 128'(upd_end), 128'h1);
    check("t1_upd_after", 128'(upd_after), 128'h0);
    check("t1_csn_idle", 128'(csn), 128'hF);
`ifndef SPI_READBACK_EN
    check("t1_rdvalid", 128'(rdv_end), 128'h0);
    check("t1_rddata", rdd_end, 128'h0);
`endif

    // Word 2: 16 bits, D=3, CPOL=1.
    xfer(8'd16, 128'h1234 << 112, 8'd3, 1'b1, 2'd0);
    check("t2_csn", 128'(csn_seen), 128'hE);
    check("t2_bits", got_bits, 128'h1234);
    check_int("t2_pulses", got_nbits, 16);
    check_int("t2_act", got_act, 64);
    check_int("t2_busy", got_busy, (2 * 16 + 2) * 4 + UD);
    check("t2_sclk_idle", 128'(sclk), 128'h1);

    // Trigger during shifting is dropped; zero width is ignored.
    data_width = 8'd4;
    data_in    = 128'hF << 124;
    clk_div    = 8'd1;
    cpol_in    = 1'b0;
    cs_sel     = 2'd1;
    trig       = 1'b1;
    @(negedge clk);
    trig    = 1'b0;
    cs_sel  = 2'd3;
    b       = 0;
    csn_mid = '0;
    for (int i = 0; i < 100 && !ready; i++) begin
      b++;
      if (i == 8) csn_mid = csn;
      trig = (i == 5);
      @(negedge clk);
    end
    trig = 1'b0;
    check_int("t3_busy", b, (2 * 4 + 2) * 2 + UD);
    check("t3_csn_mid", 128'(csn_mid), 128'hD);
    nr = 0;
    repeat (3) begin
      @(negedge clk);
      if (!ready) nr++;
    end
    check_int("t3_no_restart", nr, 0);
    data_width = 8'd0;
    trig       = 1'b1;
    nr         = 0;
    repeat (4) begin
      @(negedge clk);
      if (!ready || csn != 4'hF) nr++;
    end
    trig = 1'b0;
    check_int("t3_zero_width", nr, 0);

    // Reset at bit 5 of 32.
    data_width = 8'd32;
    data_in    = '1;
    clk_div    = 8'd0;
    cs_sel     = 2'd0;
    trig       = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    repeat (11) @(negedge clk);
    check("t4_busy_mid", 128'(ready), 128'h0);
    check("t4_csn_mid", 128'(csn), 128'hE);
    rst = 1'b1;
    @(negedge clk);
    check("t4_csn", 128'(csn), 128'hF);
    check("t4_ready", 128'(ready), 128'h1);
    check("t4_upd", 128'(upd), 128'h0);
    check("t4_mosi", 128'(mosi), 128'h0);
    rst = 1'b0;
    nr  = 0;
    repeat (80) begin
      @(negedge clk);
      if (upd || rd_valid || !ready) nr++;
    end
    check_int("t4_quiet", nr, 0);

    // Manual update mode.
    auto_upd = 1'b0;
    upd_in   = 1'b1;
    xfer(8'd8, 128'h3C << 120, 8'd1, 1'b0, 2'd3);
    check_int("t5_upd_busy", upd_busy, 0);
    check("t5_upd_end", 128'(upd_end), 128'h1);
    check("t5_upd_after", 128'(upd_after), 128'h1);
    upd_in = 1'b0;
    xfer(8'd2, 128'h0, 8'd0, 1'b0, 2'd3);
    check("t5_no_internal", 128'(upd_end), 128'h0);
    auto_upd = 1'b1;

    // Back-to-back with trigger held high.
    data_width = 8'd2;
    data_in    = '1;
    clk_div    = 8'd0;
    cs_sel     = 2'd2;
    trig       = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
    check("t6_gap_csn", 128'(csn), 128'hF);
    @(negedge clk);
    check("t6_restart", 128'(ready), 128'h0);
    check("t6_restart_csn", 128'(csn), 128'hB);
    trig = 1'b0;
    for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
    @(negedge clk);

    // Width above MAXWIDTH clamps to 128 bits.
    xfer(8'd200, 128'h0, 8'd0, 1'b0, 2'd1);
    check_int("t7_clamp_busy", got_busy, (2 * 128 + 2) * 1 + UD);

`ifdef SPI_READBACK_EN
    xfer(8'd12, 128'hABC << 116, 8'd1, 1'b0, 2'd0);
    check("t8_rdvalid", 128'(rdv_end), 128'h1);
    check("t8_rddata", rdd_end, 128'hABC);
    check("t8_rdvalid_after", 128'(rdv_after), 128'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
